// File: rtl/sram_1rw_masked_init_if.sv
`timescale 1ns/1ps
// Request/response bundle for one 1RW SRAM bank.
// Latency: none; wires only.
// Backpressure: RW0_ready gates requests, and RW0_rvalid flags read data. Neither side holds off the response.
//
// The master (the requester) drives addr/en/wmode/wmask/wdata.
// The slave (the array) drives ready/rvalid/rdata.
interface sram_1rw_masked_init_if #(
    parameter int DATA_W    = 72,
    parameter int ADDR_W    = 8,
    parameter int MASK_GRAN = 8
);
    localparam int LANES = DATA_W / MASK_GRAN;

    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [LANES-1:0]  RW0_wmask;
    logic [DATA_W-1:0] RW0_wdata;
    logic              RW0_ready;
    logic              RW0_rvalid;
    logic [DATA_W-1:0] RW0_rdata;

    modport master (
        output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        input  RW0_ready, RW0_rvalid, RW0_rdata
    );

    modport slave (
        input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
        output RW0_ready, RW0_rvalid, RW0_rdata
    );
endinterface

// File: rtl/sram_1rw_masked_init.sv
`timescale 1ns/1ps
// Single-port (1RW) SRAM bank with a per-lane write mask and a hardware init sweep that runs after every reset.
// Latency: read data appears 1 cycle after the accepting edge. A write lands on the accepting edge.
// Backpressure: RW0_ready stays 0 for DEPTH cycles after reset. Requests seen while it is 0 are dropped.
//
// Ports:
//   RW0_clk    - clock. All state changes on posedge.
//   RW0_rst_n  - asynchronous, active-low reset.
//   rw0        - slave side of sram_1rw_masked_init_if:
//                addr, en, wmode, wmask and wdata are inputs;
//                ready, rvalid and rdata are outputs.
// Optional feature: when SRAM_RDATA_HOLD_EN is defined, RW0_rdata holds the last read result while rvalid=0.
// Otherwise RW0_rdata is zero whenever rvalid=0.
module sram_1rw_masked_init #(
    parameter int                   DATA_W    = 72,
    parameter int                   DEPTH     = 256,
    parameter int                   ADDR_W    = 8,
    parameter int                   MASK_GRAN = 8,
    parameter logic [MASK_GRAN-1:0] INIT_VAL  = '0
) (
    input  logic                   RW0_clk,
    input  logic                   RW0_rst_n,
    sram_1rw_masked_init_if.slave  rw0
);

    localparam int                LANES     = DATA_W / MASK_GRAN;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // One extra bit, so that DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [DATA_W-1:0] INIT_WORD = {LANES{INIT_VAL}};

    // ------------------------------------------------------------------
    // Parameter sanity: stop elaboration on geometry the array cannot hold.
    // ------------------------------------------------------------------
    generate
        if ((DATA_W % MASK_GRAN) != 0) begin : g_bad_gran
            $error("sram_1rw_masked_init: DATA_W must be a multiple of MASK_GRAN");
        end
        if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_bad_addr
            $error("sram_1rw_masked_init: ADDR_W too narrow for DEPTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Init-sweep FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              w_sweep_we;
    logic              w_ready;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep_we  = 1'b0;
        w_ready     = 1'b0;
        case (r_state)
            ST_INIT: begin
                // One word per cycle. The cycle that writes the last word
                // also hands over to RUN, so the sweep is exactly DEPTH cycles.
                w_sweep_we = 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                w_ready = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic w_accept;
    logic w_addr_ok;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_accept  = rw0.RW0_en & w_ready;
    assign w_addr_ok = ({1'b0, rw0.RW0_addr} < DEPTH_X);
    // Out-of-range writes are dropped here. Out-of-range reads still
    // produce an rvalid, but they return zero data.
    assign w_wr_acc  = w_accept &  rw0.RW0_wmode & w_addr_ok;
    assign w_rd_acc  = w_accept & ~rw0.RW0_wmode;

    // ------------------------------------------------------------------
    // Storage: no reset, because contents are defined only by the sweep
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge RW0_clk) begin
        if (w_sweep_we) begin
            r_mem[r_cnt] <= INIT_WORD;
        end else if (w_wr_acc) begin
            for (int k = 0; k < LANES; k++) begin
                if (rw0.RW0_wmask[k]) begin
                    r_mem[rw0.RW0_addr][k*MASK_GRAN +: MASK_GRAN] <=
                        rw0.RW0_wdata[k*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: address is registered, and data comes combinationally
    // from the array during the rvalid cycle.
    // ------------------------------------------------------------------
    logic              r_rvalid;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_raddr_ok;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_rdata;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            r_rvalid   <= 1'b0;
            r_raddr    <= '0;
            r_raddr_ok <= 1'b0;
        end else begin
            r_rvalid <= w_rd_acc;
            if (w_rd_acc) begin
                r_raddr    <= rw0.RW0_addr;
                r_raddr_ok <= w_addr_ok;
            end
        end
    end

    assign w_rd_word = r_raddr_ok ? r_mem[r_raddr] : '0;

`ifdef SRAM_RDATA_HOLD_EN
    // Capture the word shown at the end of each rvalid cycle. Later writes
    // to that address leave the held copy alone.
    logic [DATA_W-1:0] r_hold;

    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            r_hold <= '0;
        end else if (r_rvalid) begin
            r_hold <= w_rd_word;
        end
    end

    assign w_rdata = r_rvalid ? w_rd_word : r_hold;
`else
    assign w_rdata = r_rvalid ? w_rd_word : '0;
`endif

    // ------------------------------------------------------------------
    // Outputs: all of them come from async-reset state, so they fall
    // to zero as soon as reset asserts.
    // ------------------------------------------------------------------
    assign rw0.RW0_ready  = w_ready;
    assign rw0.RW0_rvalid = r_rvalid;
    assign rw0.RW0_rdata  = w_rdata;

endmodule

// File: tb/tb_sram_1rw_masked_init.sv
`timescale 1ns/1ps
// Directed bench for sram_1rw_masked_init.
// It uses a 256-word bank (INIT_VAL=A5) and a 200-word bank that share clock and reset.
module tb_sram_1rw_masked_init;

    localparam int          DW = 72;
    localparam int          AW = 8;
    localparam int          MG = 8;
    localparam logic [71:0] IW   = {9{8'hA5}};
    localparam logic [71:0] D5A  = 72'h0123456789ABCDEF01;
    localparam logic [71:0] D5B  = 72'h0123456789ABCDEF00;
    localparam logic [71:0] W1   = 72'h111111111111111111;
    localparam logic [71:0] W2   = 72'h222222222222222222;
    localparam logic [71:0] W2E  = 72'hA522222222A5A5A5A5;
    localparam logic [71:0] W3   = 72'h333333333333333333;
    localparam logic [71:0] ONES = 72'hFFFFFFFFFFFFFFFFFF;
    localparam logic [71:0] F5   = 72'h00FFFFFFFFFFFFFFFF;
`ifdef SRAM_RDATA_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_1rw_masked_init_if #(.DATA_W(DW), .ADDR_W(AW), .MASK_GRAN(MG)) bus_a ();
    sram_1rw_masked_init_if #(.DATA_W(DW), .ADDR_W(AW), .MASK_GRAN(MG)) bus_b ();

    sram_1rw_masked_init #(
        .DATA_W(DW), .DEPTH(256), .ADDR_W(AW), .MASK_GRAN(MG), .INIT_VAL(8'hA5)
    ) u_dut_a (
        .RW0_clk   (clk),
        .RW0_rst_n (rst_n),
        .rw0       (bus_a.slave)
    );

    sram_1rw_masked_init #(
        .DATA_W(DW), .DEPTH(200), .ADDR_W(AW), .MASK_GRAN(MG), .INIT_VAL(8'hA5)
    ) u_dut_b (
        .RW0_clk   (clk),
        .RW0_rst_n (rst_n),
        .rw0       (bus_b.slave)
    );

    typedef struct {
        logic        en;
        logic        wm;
        logic [7:0]  addr;
        logic [8:0]  mask;
        logic [71:0] wdata;
        logic        exp_rv;
        logic [71:0] exp_rd;   // read data, or the held value when exp_rv=0
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drv_a(input logic en, input logic wm, input logic [7:0] addr,
                         input logic [8:0] mask, input logic [71:0] wdata);
        bus_a.RW0_en    = en;
        bus_a.RW0_wmode = wm;
        bus_a.RW0_addr  = addr;
        bus_a.RW0_wmask = mask;
        bus_a.RW0_wdata = wdata;
    endtask

    task automatic drv_b(input logic en, input logic wm, input logic [7:0] addr,
                         input logic [8:0] mask, input logic [71:0] wdata);
        bus_b.RW0_en    = en;
        bus_b.RW0_wmode = wm;
        bus_b.RW0_addr  = addr;
        bus_b.RW0_wmask = mask;
        bus_b.RW0_wdata = wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int first_a;
        int first_b;
        int cyc;
        bit rv_seen;
        logic [71:0] exp_rd;

        //             en    wm    addr   mask    wdata  rv    rd
        vecs[0]  = '{1'b1, 1'b0, 8'h37, 9'h000, 72'h0, 1'b1, IW};   // swept value
        vecs[1]  = '{1'b1, 1'b0, 8'h40, 9'h000, 72'h0, 1'b1, IW};   // write during INIT dropped
        vecs[2]  = '{1'b1, 1'b0, 8'h41, 9'h000, 72'h0, 1'b1, IW};
        vecs[3]  = '{1'b1, 1'b1, 8'h05, 9'h1FF, D5A,   1'b0, IW};
        vecs[4]  = '{1'b1, 1'b1, 8'h05, 9'h001, 72'h0, 1'b0, IW};   // lane 0 only
        vecs[5]  = '{1'b1, 1'b0, 8'h05, 9'h000, 72'h0, 1'b1, D5B};
        vecs[6]  = '{1'b1, 1'b1, 8'h01, 9'h1FF, W1,    1'b0, D5B};
        vecs[7]  = '{1'b1, 1'b1, 8'h02, 9'h0F0, W2,    1'b0, D5B};  // lanes 4..7
        vecs[8]  = '{1'b1, 1'b1, 8'h03, 9'h000, W3,    1'b0, D5B};  // empty mask: no-op
        vecs[9]  = '{1'b1, 1'b0, 8'h01, 9'h000, 72'h0, 1'b1, W1};
        vecs[10] = '{1'b1, 1'b0, 8'h02, 9'h000, 72'h0, 1'b1, W2E};
        vecs[11] = '{1'b1, 1'b0, 8'h03, 9'h000, 72'h0, 1'b1, IW};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 9'h000, 72'h0, 1'b0, IW};
        vecs[13] = '{1'b1, 1'b0, 8'h05, 9'h000, 72'h0, 1'b1, D5B};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 9'h000, 72'h0, 1'b0, D5B};
        vecs[15] = '{1'b1, 1'b1, 8'h05, 9'h1FF, ONES,  1'b0, D5B};  // held copy unaffected
        vecs[16] = '{1'b0, 1'b0, 8'h00, 9'h000, 72'h0, 1'b0, D5B};
        vecs[17] = '{1'b1, 1'b0, 8'h05, 9'h000, 72'h0, 1'b1, ONES};
        vecs[18] = '{1'b1, 1'b1, 8'h05, 9'h100, 72'h0, 1'b0, ONES}; // top lane only
        vecs[19] = '{1'b1, 1'b0, 8'h05, 9'h000, 72'h0, 1'b1, F5};
        vecs[20] = '{1'b1, 1'b0, 8'hFF, 9'h000, 72'h0, 1'b1, IW};   // last word
        vecs[21] = '{1'b1, 1'b0, 8'h00, 9'h000, 72'h0, 1'b1, IW};
        vecs[22] = '{1'b0, 1'b1, 8'h00, 9'h1FF, 72'h0, 1'b0, IW};   // en=0 write ignored
        vecs[23] = '{1'b1, 1'b0, 8'h00, 9'h000, 72'h0, 1'b1, IW};

        drv_a(1'b0, 1'b0, 8'h00, 9'h000, 72'h0);
        drv_b(1'b0, 1'b0, 8'h00, 9'h000, 72'h0);

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_ready_a",  {71'b0, bus_a.RW0_ready},  72'h0);
        chk("rst_rvalid_a", {71'b0, bus_a.RW0_rvalid}, 72'h0);
        chk("rst_rdata_a",  bus_a.RW0_rdata,           72'h0);
        chk("rst_ready_b",  {71'b0, bus_b.RW0_ready},  72'h0);

        // ---------------- init sweep, with requests issued during INIT ----------------
        rst_n   = 1'b1;
        first_a = -1;
        first_b = -1;
        rv_seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (first_a < 0 && bus_a.RW0_ready === 1'b1) first_a = c;
            if (first_b < 0 && bus_b.RW0_ready === 1'b1) first_b = c;
            if (bus_a.RW0_rvalid !== 1'b0) rv_seen = 1'b1;
            if (first_a >= 0 && first_b >= 0) break;
            if (c == 10)      drv_a(1'b1, 1'b1, 8'h40, 9'h1FF, ONES);
            else if (c == 11) drv_a(1'b1, 1'b0, 8'h41, 9'h000, 72'h0);
            else              drv_a(1'b0, 1'b0, 8'h00, 9'h000, 72'h0);
            step();
        end
        chk("sweep_ready_cycle_a", 72'(first_a), 72'd256);
        chk("sweep_ready_cycle_b", 72'(first_b), 72'd200);
        chk("init_no_rvalid",      {71'b0, rv_seen}, 72'h0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < NV; i++) begin
            drv_a(vecs[i].en, vecs[i].wm, vecs[i].addr, vecs[i].mask, vecs[i].wdata);
            step();
            exp_rd = (vecs[i].exp_rv || HOLD) ? vecs[i].exp_rd : 72'h0;
            chk($sformatf("vec%0d_rvalid", i), {71'b0, bus_a.RW0_rvalid}, {71'b0, vecs[i].exp_rv});
            chk($sformatf("vec%0d_rdata", i),  bus_a.RW0_rdata, exp_rd);
        end

        // ---------------- out-of-range address on DEPTH=200 bank ----------------
        drv_b(1'b1, 1'b1, 8'd250, 9'h1FF, ONES);
        step();
        drv_b(1'b1, 1'b0, 8'd250, 9'h000, 72'h0);
        step();
        chk("oor_rvalid", {71'b0, bus_b.RW0_rvalid}, 72'h1);
        chk("oor_rdata",  bus_b.RW0_rdata, 72'h0);
        drv_b(1'b1, 1'b0, 8'd50, 9'h000, 72'h0);
        step();
        chk("alias50_rdata", bus_b.RW0_rdata, IW);
        drv_b(1'b1, 1'b0, 8'd199, 9'h000, 72'h0);
        step();
        chk("last199_rdata", bus_b.RW0_rdata, IW);
        drv_b(1'b0, 1'b0, 8'd0, 9'h000, 72'h0);
        step();
        chk("b_idle_rvalid", {71'b0, bus_b.RW0_rvalid}, 72'h0);
        chk("b_idle_rdata",  bus_b.RW0_rdata, HOLD ? IW : 72'h0);

        // ---------------- reset during an in-flight read ----------------
        drv_a(1'b1, 1'b0, 8'h05, 9'h000, 72'h0);
        step();
        chk("pre_rst_rvalid", {71'b0, bus_a.RW0_rvalid}, 72'h1);
        chk("pre_rst_rdata",  bus_a.RW0_rdata, F5);
        drv_a(1'b0, 1'b0, 8'h00, 9'h000, 72'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready",  {71'b0, bus_a.RW0_ready},  72'h0);
        chk("async_rst_rvalid", {71'b0, bus_a.RW0_rvalid}, 72'h0);
        chk("async_rst_rdata",  bus_a.RW0_rdata, 72'h0);
        repeat (2) step();
        rst_n = 1'b1;
        cyc   = 0;
        while (bus_a.RW0_ready !== 1'b1 && cyc < 400) begin
            step();
            cyc++;
        end
        chk("resweep_cycles", 72'(cyc), 72'd256);
        drv_a(1'b1, 1'b0, 8'h05, 9'h000, 72'h0);
        step();
        chk("resweep_rd5_rvalid", {71'b0, bus_a.RW0_rvalid}, 72'h1);
        chk("resweep_rd5_rdata",  bus_a.RW0_rdata, IW);
        drv_a(1'b1, 1'b0, 8'h01, 9'h000, 72'h0);
        step();
        chk("resweep_rd1_rdata",  bus_a.RW0_rdata, IW);
        drv_a(1'b0, 1'b0, 8'h00, 9'h000, 72'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
